room_renderer: RTL and testbench

Parametrised room background generator for the VGA pixel pipeline. For each pixel coordinate from the VGA timing generator it returns the room's background colour: a floor with a wall band on all four sides and an optional doorway in each band. Doorways slide open and closed over several frames under game-logic control. It replaces the fixed single-doorway hallway renderers and sits between the VGA timing generator and the sprite/overlay mixer.

---
 rtl/room_pkg.sv | 26 ++
 rtl/door_slider.sv | 57 +++++
 rtl/room_renderer.sv | 112 +++++++++++
 tb/tb_room_renderer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/room_pkg.sv
// Shared constants, slider state type and gap helper for the room background renderer.
package room_pkg;

  localparam logic [1:0] SIDE_N = 2'd0;
  localparam logic [1:0] SIDE_S = 2'd1;
  localparam logic [1:0] SIDE_E = 2'd2;
  localparam logic [1:0] SIDE_W = 2'd3;

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } slider_state_t;

  localparam logic [7:0] COLOR_BLACK         = 8'h00;
  localparam logic [7:0] COLOR_FLOOR_DEFAULT = 8'b10110110;

  // Written as coord + half >= mid so the lower bound never underflows.
  function automatic logic in_gap(input logic [10:0] coord,
                                  input logic [10:0] mid,
                                  input logic [10:0] half);
    return (coord + half >= mid) && (coord < mid + half);
  endfunction

endpackage

// File: rtl/door_slider.sv
// One doorway slider: steps its half-width toward open or closed on each frame_start.
module door_slider
  import room_pkg::*;
#(
  parameter int unsigned HALF_MAX = 60,
  parameter int unsigned STEP     = 4,
  parameter int unsigned HW       = $clog2(HALF_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          lock,
  output logic [HW-1:0] h,
  output logic          open,
  output logic          moving
);

  localparam logic [HW-1:0] STEP_W = HW'(STEP);
  localparam logic [HW-1:0] MAX_W  = HW'(HALF_MAX);

  slider_state_t state;

  // A reversal mid-travel takes its step on the same pulse, so every pulse
  // moves h one STEP toward the locked/unlocked target until it is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLOSED;
      h      <= '0;
      open   <= 1'b0;
      moving <= 1'b0;
    end else if (frame_start) begin
      if (lock && state != CLOSED) begin
        h    <= h - STEP_W;
        open <= 1'b0;
        if (h == STEP_W) begin
          state  <= CLOSED;
          moving <= 1'b0;
        end else begin
          state  <= CLOSING;
          moving <= 1'b1;
        end
      end else if (!lock && state != OPEN) begin
        h <= h + STEP_W;
        if (h + STEP_W == MAX_W) begin
          state  <= OPEN;
          open   <= 1'b1;
          moving <= 1'b0;
        end else begin
          state  <= OPENING;
          open   <= 1'b0;
          moving <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/room_renderer.sv
// Room background generator: four wall bands with sliding doorways, 2-cycle pixel pipeline.
module room_renderer
  import room_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned WALL_T      = 40,
  parameter int unsigned HALF_MAX    = 60,
  parameter int unsigned STEP        = 4,
  parameter logic [7:0]  FLOOR_COLOR = COLOR_FLOOR_DEFAULT
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic [9:0] CurrentX,
  input  logic [8:0] CurrentY,
  input  logic [7:0] wall,
  input  logic       frame_start,
  input  logic [3:0] door_mask,
  input  logic [3:0] door_lock,
  output logic [7:0] mapData,
  output logic [3:0] door_open,
  output logic [3:0] door_moving
);

  localparam int unsigned HW = $clog2(HALF_MAX + 1);

  localparam logic [10:0] X_END  = 11'(H_RES);
  localparam logic [10:0] Y_END  = 11'(V_RES);
  localparam logic [10:0] X_MID  = 11'(H_RES / 2);
  localparam logic [10:0] Y_MID  = 11'(V_RES / 2);
  localparam logic [10:0] BAND   = 11'(WALL_T);
  localparam logic [10:0] X_EAST = 11'(H_RES - WALL_T);
  localparam logic [10:0] Y_SOUTH = 11'(V_RES - WALL_T);

  logic [HW-1:0] h_live [4];
  logic [HW-1:0] h_snap [4];
  logic          fs_d;

  for (genvar g = 0; g < 4; g++) begin : g_slider
    door_slider #(
      .HALF_MAX (HALF_MAX),
      .STEP     (STEP),
      .HW       (HW)
    ) u_slider (
      .clk         (clk_vga),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .lock        (door_lock[g]),
      .h           (h_live[g]),
      .open        (door_open[g]),
      .moving      (door_moving[g])
    );
  end

  // Snapshot follows the slider by one cycle so a whole frame renders one width.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      fs_d <= 1'b0;
      for (int unsigned s = 0; s < 4; s++) h_snap[s] <= '0;
    end else begin
      fs_d <= frame_start;
      if (fs_d) h_snap <= h_live;
    end
  end

  logic [10:0] x, y;
  logic        valid_c;
  logic [3:0]  band_c, gap_c;

  assign x = {1'b0, CurrentX};
  assign y = {2'b00, CurrentY};

  always_comb begin
    valid_c = (x < X_END) && (y < Y_END);
    band_c  = '0;
    gap_c   = '0;
    band_c[SIDE_N] = y < BAND;
    band_c[SIDE_S] = y >= Y_SOUTH;
    band_c[SIDE_E] = x >= X_EAST;
    band_c[SIDE_W] = x < BAND;
    gap_c[SIDE_N]  = door_mask[SIDE_N] & in_gap(x, X_MID, 11'(h_snap[SIDE_N]));
    gap_c[SIDE_S]  = door_mask[SIDE_S] & in_gap(x, X_MID, 11'(h_snap[SIDE_S]));
    gap_c[SIDE_E]  = door_mask[SIDE_E] & in_gap(y, Y_MID, 11'(h_snap[SIDE_E]));
    gap_c[SIDE_W]  = door_mask[SIDE_W] & in_gap(y, Y_MID, 11'(h_snap[SIDE_W]));
  end

  logic       valid1;
  logic [3:0] band1, gap1;
  logic [7:0] wall1;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      valid1  <= 1'b0;
      band1   <= '0;
      gap1    <= '0;
      wall1   <= '0;
      mapData <= COLOR_BLACK;
    end else begin
      valid1 <= valid_c;
      band1  <= band_c;
      gap1   <= gap_c;
      wall1  <= wall;
      if (!valid1)
        mapData <= COLOR_BLACK;
      else if (|(band1 & ~gap1))
        mapData <= wall1;
      else
        mapData <= FLOOR_COLOR;
    end
  end

endmodule

// File: tb/tb_room_renderer.sv
// Randomised and directed check of room_renderer against a behavioural room model.
module tb_room_renderer;

  logic       clk_vga = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] CurrentX = '0;
  logic [8:0] CurrentY = '0;
  logic [7:0] wall = 8'hE0;
  logic       frame_start = 1'b0;
  logic [3:0] door_mask = '0;
  logic [3:0] door_lock = '1;
  logic [7:0] mapData;
  logic [3:0] door_open, door_moving;

  always #5 clk_vga = ~clk_vga;

  room_renderer #(
    .H_RES    (640),
    .V_RES    (480),
    .WALL_T   (40),
    .HALF_MAX (60),
    .STEP     (4)
  ) dut (
    .clk_vga     (clk_vga),
    .rst_n       (rst_n),
    .CurrentX    (CurrentX),
    .CurrentY    (CurrentY),
    .wall        (wall),
    .frame_start (frame_start),
    .door_mask   (door_mask),
    .door_lock   (door_lock),
    .mapData     (mapData),
    .door_open   (door_open),
    .door_moving (door_moving)
  );

  int errors = 0;
  int checks = 0;

  // Model: per-side half-width, displayed snapshot, two-deep colour pipe.
  int         hm   [4] = '{default: 0};
  int         snap [4] = '{default: 0};
  logic [7:0] pend = 8'h00;
  logic [7:0] exp_map = 8'h00;
  logic       fs_prev = 1'b0;

  function automatic logic [7:0] ref_colour(int x, int y, logic [7:0] w, logic [3:0] m);
    bit band, gap;
    int h;
    if (x >= 640 || y >= 480) return 8'h00;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       band = (y < 40);
        1:       band = (y >= 440);
        2:       band = (x >= 600);
        default: band = (x < 40);
      endcase
      h = snap[s];
      if (s < 2) gap = m[s] && (x >= 320 - h) && (x < 320 + h);
      else       gap = m[s] && (y >= 240 - h) && (y < 240 + h);
      if (band && !gap) return w;
    end
    return 8'hB6;
  endfunction

  always @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hm      <= '{default: 0};
      snap    <= '{default: 0};
      pend    <= 8'h00;
      exp_map <= 8'h00;
      fs_prev <= 1'b0;
    end else begin
      exp_map <= pend;
      pend    <= ref_colour(int'(CurrentX), int'(CurrentY), wall, door_mask);
      if (fs_prev) snap <= hm;
      if (frame_start)
        for (int s = 0; s < 4; s++)
          hm[s] <= door_lock[s] ? ((hm[s] >= 4) ? hm[s] - 4 : 0)
                                : ((hm[s] + 4 <= 60) ? hm[s] + 4 : 60);
      fs_prev <= frame_start;
    end
  end

  function automatic logic [3:0] exp_open();
    logic [3:0] r;
    for (int s = 0; s < 4; s++) r[s] = (hm[s] == 60);
    return r;
  endfunction

  function automatic logic [3:0] exp_moving();
    logic [3:0] r;
    for (int s = 0; s < 4; s++) r[s] = (hm[s] != 0) && (hm[s] != 60);
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: advance to the falling edge and compare against the model.
  task automatic tick();
    @(negedge clk_vga);
    chk("mapData", mapData, exp_map);
    chk("door_open", {4'b0, door_open}, {4'b0, exp_open()});
    chk("door_moving", {4'b0, door_moving}, {4'b0, exp_moving()});
  endtask

  task automatic pixel(input int x, input int y, input logic [7:0] exp, input string name);
    CurrentX = 10'(x);
    CurrentY = 9'(y);
    tick();
    tick();
    chk(name, mapData, exp);
  endtask

  task automatic pulse(input logic [3:0] lock);
    door_lock   = lock;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  int xs [17] = '{0, 39, 40, 259, 260, 279, 280, 319, 320, 360, 379, 380, 599, 600, 639, 640, 1023};
  int ys [14] = '{0, 39, 40, 179, 180, 239, 240, 299, 300, 439, 440, 479, 480, 511};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_map", mapData, 8'h00);
    chk("reset_open", {4'b0, door_open}, 8'h00);
    chk("reset_moving", {4'b0, door_moving}, 8'h00);
    rst_n = 1'b1;

    // Solid walls, no doorways
    door_mask = 4'b0000;
    wall = 8'hE0;
    pixel(39, 100, 8'hE0, "w_band_edge");
    pixel(40, 100, 8'hB6, "w_floor_edge");
    pixel(600, 200, 8'hE0, "e_band_edge");
    pixel(599, 200, 8'hB6, "e_floor_edge");
    pixel(320, 39, 8'hE0, "n_band_solid");
    pixel(100, 40, 8'hB6, "n_floor_edge");
    pixel(100, 440, 8'hE0, "s_band_edge");
    pixel(100, 439, 8'hB6, "s_floor_edge");
    for (int y = 0; y < 480; y += 37)
      for (int x = 0; x < 640; x += 13) begin
        CurrentX = 10'(x);
        CurrentY = 9'(y);
        tick();
      end

    // North doorway opens over 15 pulses
    door_mask = 4'b0001;
    pulse(4'h0);
    chk("n_moving_p1", {7'b0, door_moving[0]}, 8'd1);
    repeat (14) pulse(4'h0);
    chk("n_open_p15", {7'b0, door_open[0]}, 8'd1);
    pixel(259, 10, 8'hE0, "gap60_left_wall");
    pixel(260, 10, 8'hB6, "gap60_left_floor");
    pixel(379, 10, 8'hB6, "gap60_right_floor");
    pixel(380, 10, 8'hE0, "gap60_right_wall");

    // Close, reopen to 32, then reverse
    repeat (15) pulse(4'hF);
    repeat (8) pulse(4'h0);
    pulse(4'hF);
    chk("rev_moving", {7'b0, door_moving[0]}, 8'd1);
    pixel(291, 10, 8'hE0, "gap28_left_wall");
    pixel(292, 10, 8'hB6, "gap28_left_floor");
    pixel(348, 10, 8'hE0, "gap28_right_wall");
    repeat (7) pulse(4'hF);
    chk("rev_closed_moving", {7'b0, door_moving[0]}, 8'd0);
    chk("rev_closed_open", {7'b0, door_open[0]}, 8'd0);

    // All doors open
    door_mask = 4'hF;
    repeat (15) pulse(4'h0);
    chk("all_open", {4'b0, door_open}, 8'h0F);
    pixel(0, 0, 8'hE0, "corner_nw");
    pixel(639, 0, 8'hE0, "corner_ne");
    pixel(0, 479, 8'hE0, "corner_sw");
    pixel(639, 479, 8'hE0, "corner_se");
    pixel(0, 240, 8'hB6, "w_door_floor");
    pixel(640, 10, 8'h00, "x_blank");
    pixel(100, 480, 8'h00, "y_blank");

    // Asynchronous reset mid-frame
    CurrentX = 10'd200;
    CurrentY = 9'd100;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_map", mapData, 8'h00);
    chk("midreset_open", {4'b0, door_open}, 8'h00);
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    rst_n = 1'b1;
    repeat (14) pulse(4'h0);
    chk("reopen_p14", {4'b0, door_open}, 8'h00);
    pulse(4'h0);
    chk("reopen_p15", {4'b0, door_open}, 8'h0F);

    // frame_start mid-line while the north door moves
    repeat (15) pulse(4'hF);
    door_mask = 4'b0001;
    repeat (5) pulse(4'h0);
    for (int x = 280; x <= 360; x++) begin
      CurrentX = 10'(x);
      CurrentY = 9'd5;
      frame_start = (x == 300);
      tick();
    end
    frame_start = 1'b0;
    pixel(296, 5, 8'hB6, "midline_new_gap");
    pixel(295, 5, 8'hE0, "midline_new_wall");

    // Random traffic, including back-to-back frame pulses
    for (int i = 0; i < 20000; i++) begin
      CurrentX = ($urandom_range(0, 3) == 0) ? 10'(xs[$urandom_range(0, 16)])
                                             : 10'($urandom_range(0, 700));
      CurrentY = ($urandom_range(0, 3) == 0) ? 9'(ys[$urandom_range(0, 13)])
                                             : 9'($urandom_range(0, 511));
      wall = 8'($urandom);
      if ($urandom_range(0, 199) == 0) door_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0)   door_lock = 4'($urandom);
      frame_start = ($urandom_range(0, 15) == 0) || (frame_start && $urandom_range(0, 1) == 0);
      tick();
    end
    frame_start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
